// File: rtl/rv32im_pkg.sv
// Shared RV32IM definitions: M-extension op codes, MDU state encoding, constants and
// result-select helpers used by the iterative multiply/divide unit.
package rv32im_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } mdu_state_e;

  localparam logic [31:0] DIV0_Q  = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  function automatic logic signed_a(mdu_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic signed_b(mdu_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

  // Magnitude product -> architectural result (low word for MUL, high word otherwise).
  function automatic logic [31:0] mul_select(mdu_op_e op, logic [63:0] prod, logic neg);
    logic [63:0] p;
    p = neg ? -prod : prod;
    return (op == OP_MUL) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] div_select(mdu_op_e op, logic [31:0] quot, logic [31:0] rem,
                                             logic neg_q, logic neg_r);
    if (op inside {OP_REM, OP_REMU}) return neg_r ? -rem : rem;
    return neg_q ? -quot : quot;
  endfunction

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module mdu_divstep
  import rv32im_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic            dividend_msb,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic            q_bit
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // rem < divisor always holds, so a clear top bit of diff means no borrow.
  assign shifted  = {rem, dividend_msb};
  assign diff     = shifted - {1'b0, divisor};
  assign q_bit    = ~diff[XLEN];
  assign rem_next = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];

endmodule

// File: rtl/mdu_iterative.sv
// Multi-cycle RV32 M-extension unit: 32-step shift-add multiply, 32-step restoring divide.
// Build option MDU_FAST_MUL_EN replaces the iterative multiply with a one-cycle product.
module mdu_iterative
  import rv32im_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            valid_i,
  input  logic            kill_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] srca_i,
  input  logic [XLEN-1:0] srcb_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  mdu_state_e       state_q;
  mdu_op_e          op_q;
  logic [CNT_W-1:0] cnt_q;
  logic             neg_res_q, neg_rem_q;
  logic [XLEN-1:0]  hi_q, lo_q, b_q;

  // Accept-time decode of the incoming operands.
  mdu_op_e         op_in;
  logic            sign_a, sign_b, div0, ovf, accept, last_iter;
  logic [XLEN-1:0] mag_a, mag_b, special_res;

  assign op_in       = mdu_op_e'(funct3_i);
  assign sign_a      = signed_a(op_in) & srca_i[XLEN-1];
  assign sign_b      = signed_b(op_in) & srcb_i[XLEN-1];
  assign mag_a       = sign_a ? -srca_i : srca_i;
  assign mag_b       = sign_b ? -srcb_i : srcb_i;
  assign div0        = funct3_i[2] & (srcb_i == '0);
  assign ovf         = (op_in inside {OP_DIV, OP_REM}) & (srca_i == INT_MIN) & (srcb_i == '1);
  assign special_res = div0 ? (funct3_i[1] ? srca_i : DIV0_Q) : (funct3_i[1] ? '0 : INT_MIN);
  assign accept      = (state_q == IDLE) & valid_i & ~kill_i;
  assign last_iter   = (cnt_q == CNT_W'(XLEN - 1));

  assign stall_o = accept | (state_q == MUL) | (state_q == DIV);
  assign done_o  = (state_q == DONE) & ~kill_i;

  // Division: hi_q is the partial remainder, lo_q shifts dividend bits out and quotient bits in.
  logic [XLEN-1:0] div_rem_nx;
  logic            div_qbit;
  logic [XLEN-1:0] div_quo_nx;

  mdu_divstep #(.XLEN(XLEN)) u_divstep (
    .rem          (hi_q),
    .dividend_msb (lo_q[XLEN-1]),
    .divisor      (b_q),
    .rem_next     (div_rem_nx),
    .q_bit        (div_qbit)
  );

  assign div_quo_nx = {lo_q[XLEN-2:0], div_qbit};

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
`else
  // Shift-add: {hi_q, lo_q} holds the running product with the multiplier in the low half.
  logic [XLEN:0]   mul_sum;
  logic [XLEN-1:0] mul_hi_nx, mul_lo_nx;
  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
  assign mul_hi_nx = mul_sum[XLEN:1];
  assign mul_lo_nx = {mul_sum[0], lo_q[XLEN-1:1]};
`endif

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= IDLE;
      op_q      <= OP_MUL;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      b_q       <= '0;
      result_o  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            op_q      <= op_in;
            neg_res_q <= sign_a ^ sign_b;
            neg_rem_q <= sign_a;
            b_q       <= mag_b;
            hi_q      <= '0;
            lo_q      <= mag_a;
            cnt_q     <= '0;
            if (div0 || ovf) begin
              result_o <= special_res;
              state_q  <= DONE;
            end else if (funct3_i[2]) begin
              state_q <= DIV;
            end else begin
`ifdef MDU_FAST_MUL_EN
              result_o <= mul_select(op_in, fast_prod, sign_a ^ sign_b);
              state_q  <= DONE;
`else
              state_q <= MUL;
`endif
            end
          end
        end
`ifndef MDU_FAST_MUL_EN
        MUL: begin
          if (kill_i) begin
            state_q <= IDLE;
          end else begin
            hi_q  <= mul_hi_nx;
            lo_q  <= mul_lo_nx;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_iter) begin
              result_o <= mul_select(op_q, {mul_hi_nx, mul_lo_nx}, neg_res_q);
              state_q  <= DONE;
            end
          end
        end
`endif
        DIV: begin
          if (kill_i) begin
            state_q <= IDLE;
          end else begin
            hi_q  <= div_rem_nx;
            lo_q  <= div_quo_nx;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_iter) begin
              result_o <= div_select(op_q, div_quo_nx, div_rem_nx, neg_res_q, neg_rem_q);
              state_q  <= DONE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative against an arithmetic reference model;
// honours MDU_FAST_MUL_EN for the expected multiply latency.
module tb_mdu_iterative;
  import rv32im_pkg::*;

  logic        clk = 1'b0;
  logic        clr, valid_i, kill_i;
  logic [2:0]  funct3_i;
  logic [31:0] srca_i, srcb_i;
  logic        stall_o, done_o;
  logic [31:0] result_o;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  always #5 clk = ~clk;

  mdu_iterative dut (
    .clk      (clk),
    .clr      (clr),
    .valid_i  (valid_i),
    .kill_i   (kill_i),
    .funct3_i (funct3_i),
    .srca_i   (srca_i),
    .srcb_i   (srcb_i),
    .stall_o  (stall_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  // RISC-V M-extension semantics written directly with wide arithmetic.
  function automatic logic [31:0] ref_result(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    logic signed [63:0] sa, sb, sp;
    logic        [63:0] ua, ub, up;
    logic signed [31:0] a32, b32;
    logic               overflow;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    a32 = a;
    b32 = b;
    overflow = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin sp = sa * sb; return sp[31:0]; end
      3'd1: begin sp = sa * sb; return sp[63:32]; end
      3'd2: begin sp = sa * $signed(ub); return sp[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : overflow ? 32'h8000_0000 : 32'(a32 / b32);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : overflow ? 32'd0 : 32'(a32 % b32);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    if (!f[2]) return MUL_LAT;
    if (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    return 33;
  endfunction

  // Called #1 after the accept edge; returns #1 into the cycle where done_o is high.
  task automatic wait_done(input string name, input logic [31:0] exp, input int exp_lat);
    int lat = 1;
    while (done_o !== 1'b1 && lat <= 40) begin
      n_checks++;
      if (stall_o !== 1'b1) begin
        n_fail++;
        $display("FAIL %s stall_busy cycle=%0d got=%b exp=1", name, lat, stall_o);
      end
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (done_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s timeout no done_o within %0d cycles", name, lat - 1);
      return;
    end
    n_checks++;
    if (lat !== exp_lat) begin
      n_fail++;
      $display("FAIL %s latency got=%0d exp=%0d", name, lat, exp_lat);
    end
    n_checks++;
    if (result_o !== exp) begin
      n_fail++;
      $display("FAIL %s result got=%h exp=%h", name, result_o, exp);
    end
    n_checks++;
    if (stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s stall_in_done got=%b exp=0", name, stall_o);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    valid_i = 1'b1; funct3_i = f; srca_i = a; srcb_i = b;
    #1;
    n_checks++;
    if (stall_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s stall_accept got=%b exp=1", name, stall_o);
    end
    @(posedge clk); #1;
    valid_i = 1'b0; funct3_i = 3'($urandom); srca_i = $urandom; srcb_i = $urandom;
    wait_done(name, exp, ref_latency(f, a, b));
    @(posedge clk); #1;
    n_checks++;
    if (done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_pulse got=%b exp=0", name, done_o);
    end
  endtask

  task automatic test_reset();
    clr = 1'b0; valid_i = 1'b0; kill_i = 1'b0; funct3_i = '0; srca_i = '0; srcb_i = '0;
    #2 clr = 1'b1;
    #1;
    n_checks++;
    if ({stall_o, done_o, result_o} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset outputs got=%b/%b/%h exp=0/0/0", stall_o, done_o, result_o);
    end
    @(posedge clk); #1 clr = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    run_op("mul_7x-3",        3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_op("mulhu_max",       3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("mulh_intmin",     3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_op("mulhsu_-1x2",     3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF);
  endtask

  task automatic test_div();
    run_op("div_-7/2",        3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    run_op("rem_-7/2",        3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    run_op("divu_100/7",      3'b101, 32'd100,       32'd7,         32'd14);
    run_op("remu_100/7",      3'b111, 32'd100,       32'd7,         32'd2);
  endtask

  task automatic test_special();
    run_op("div_by_zero",     3'b100, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF);
    run_op("remu_by_zero",    3'b111, 32'd5,         32'd0,         32'd5);
    run_op("div_overflow",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("rem_overflow",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
  endtask

  task automatic test_kill();
    bit saw_done = 0;
    run_op("kill_setup",      3'b101, 32'd100,       32'd7,         32'd14);
    // kill in IDLE blocks the accept
    valid_i = 1'b1; kill_i = 1'b1; funct3_i = 3'b101; srca_i = 32'd50; srcb_i = 32'd3;
    #1;
    n_checks++;
    if (stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL kill_idle stall got=%b exp=0", stall_o);
    end
    @(posedge clk); #1 valid_i = 1'b0; kill_i = 1'b0;
    // kill during cycle 10 of a DIV
    valid_i = 1'b1; funct3_i = 3'b100; srca_i = 32'hFFFF_FC18; srcb_i = 32'd7;
    @(posedge clk); #1 valid_i = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    kill_i = 1'b1;
    @(posedge clk); #1 kill_i = 1'b0;
    n_checks++;
    if (stall_o !== 1'b0 || done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL kill_div idle got stall=%b done=%b exp 0/0", stall_o, done_o);
    end
    repeat (40) begin
      @(posedge clk); #1;
      if (done_o === 1'b1) saw_done = 1;
    end
    n_checks++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL kill_div spurious done_o got=1 exp=0");
    end
    n_checks++;
    if (result_o !== 32'd14) begin
      n_fail++;
      $display("FAIL kill_div result_hold got=%h exp=%h", result_o, 32'd14);
    end
    run_op("after_kill",      3'b100, 32'hFFFF_FC18, 32'd7, ref_result(3'b100, 32'hFFFF_FC18, 32'd7));
  endtask

  task automatic test_clr();
    bit saw_done = 0;
`ifdef MDU_FAST_MUL_EN
    valid_i = 1'b1; funct3_i = 3'b101; srca_i = 32'd999; srcb_i = 32'd4;
`else
    valid_i = 1'b1; funct3_i = 3'b000; srca_i = 32'd999; srcb_i = 32'd4;
`endif
    @(posedge clk); #1 valid_i = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    clr = 1'b1;
    #1;
    n_checks++;
    if ({stall_o, done_o, result_o} !== 34'd0) begin
      n_fail++;
      $display("FAIL clr_mid outputs got=%b/%b/%h exp=0/0/0", stall_o, done_o, result_o);
    end
    @(posedge clk); #1 clr = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done_o === 1'b1) saw_done = 1;
    end
    n_checks++;
    if (saw_done || result_o !== 32'd0) begin
      n_fail++;
      $display("FAIL clr_mid after got done_seen=%0d result=%h exp 0/0", saw_done, result_o);
    end
  endtask

  task automatic test_back_to_back();
    valid_i = 1'b1; funct3_i = 3'b101; srca_i = 32'd1000; srcb_i = 32'd9;
    @(posedge clk); #1 valid_i = 1'b0;
    wait_done("b2b_first", 32'd111, 33);
    valid_i = 1'b1; funct3_i = 3'b101; srca_i = 32'd77; srcb_i = 32'd5;
    @(posedge clk); #1;
    n_checks++;
    if (done_o !== 1'b0 || stall_o !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_gap got done=%b stall=%b exp 0/1", done_o, stall_o);
    end
    @(posedge clk); #1 valid_i = 1'b0; srca_i = $urandom; srcb_i = $urandom;
    wait_done("b2b_second", 32'd15, 33);
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [2:0]  f;
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      f = 3'($urandom);
      case ($urandom_range(0, 4))
        0:       a = 32'h8000_0000;
        1:       a = 32'($urandom_range(0, 20));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      run_op($sformatf("rand%0d_f%0d", i, f), f, a, b, ref_result(f, a, b));
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_kill();
    test_clr();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
